// File: rtl/matmul_pkg.sv
// Shared definitions for the 2x2 8-bit matrix multiply block.
// Holds:
//   - the sequencer state encoding;
//   - operand and result counts and widths;
//   - the operand slot numbering used on the datapath sel_in bus;
//   - a helper that sizes the sequencer's latency counter.
package matmul_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StSettle,
        StExec,
        StWait,
        StRsel,
        StOut
    } mm_state_e;

    localparam int unsigned MM_OPERANDS = 8;
    localparam int unsigned MM_RESULTS  = 4;
    localparam int unsigned MM_IN_W     = 8;
    localparam int unsigned MM_RES_W    = 17;

    // Operand slot numbering on the datapath sel_in bus.
    localparam logic [2:0] SLOT_A00 = 3'd0;
    localparam logic [2:0] SLOT_A01 = 3'd1;
    localparam logic [2:0] SLOT_A10 = 3'd2;
    localparam logic [2:0] SLOT_A11 = 3'd3;
    localparam logic [2:0] SLOT_B00 = 3'd4;
    localparam logic [2:0] SLOT_B01 = 3'd5;
    localparam logic [2:0] SLOT_B10 = 3'd6;
    localparam logic [2:0] SLOT_B11 = 3'd7;

    // Width needed to hold the larger of two latency values.
    // The result is never narrower than 3 bits.
    function automatic int unsigned lat_cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        int unsigned w;
        m = (a > b) ? a : b;
        w = $clog2(m + 1);
        return (w > 3) ? w : 3;
    endfunction

endpackage

// File: rtl/matmul_sequencer.sv
// Sequencer that drives the 2x2 8-bit matrix_multiply datapath end to end.
//
// Operation:
//   - Accepts eight operand bytes on a valid/ready stream. They are written in order to
//     operand slots A00, A01, A10, A11, B00, B01, B10, B11.
//   - Pulses mm_execute once.
//   - Reads the four 17-bit products back as a valid/ready result stream, in the order
//     C00, C01, C10, C11.
//
// Ports:
//   clk, reset         single clock; synchronous active-high reset
//   start              begin a job (only honoured in idle)
//   in_data/in_valid   operand byte stream, in_ready accepts
//   out_data/out_valid result word stream, out_ready accepts
//   busy               high whenever not idle
//   done               one-cycle pulse after the 4th result is accepted
//   mm_sel_in          datapath operand slot
//   mm_input_val       datapath operand value
//   mm_execute         datapath compute strobe
//   mm_sel_out         datapath result select
//   mm_result          datapath result
module matmul_sequencer
    import matmul_pkg::*;
#(
    parameter int unsigned EXEC_LAT = 2,
    parameter int unsigned READ_LAT = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [MM_IN_W-1:0]  in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [MM_RES_W-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy,
    output logic                done,
    output logic [2:0]          mm_sel_in,
    output logic [MM_IN_W-1:0]  mm_input_val,
    output logic                mm_execute,
    output logic [1:0]          mm_sel_out,
    input  logic [MM_RES_W-1:0] mm_result
);

    localparam int unsigned CntW = lat_cnt_width(EXEC_LAT, READ_LAT);
    localparam logic [1:0]  LastRes = 2'(MM_RESULTS - 1);

    mm_state_e           state_q, state_d;
    logic [2:0]          op_idx_q, op_idx_d;
    logic [1:0]          res_idx_q, res_idx_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [MM_RES_W-1:0] out_data_d;
    logic                out_valid_d;
    logic                done_d;
    logic [2:0]          sel_in_d;
    logic [MM_IN_W-1:0]  input_val_d;
    logic                execute_d;
    logic [1:0]          sel_out_d;

    assign in_ready = (state_q == StLoad);
    assign busy     = (state_q != StIdle);

    always_comb begin
        state_d     = state_q;
        op_idx_d    = op_idx_q;
        res_idx_d   = res_idx_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data;
        out_valid_d = out_valid;
        done_d      = 1'b0;
        sel_in_d    = mm_sel_in;
        input_val_d = mm_input_val;
        execute_d   = 1'b0;
        sel_out_d   = mm_sel_out;

        case (state_q)
            StIdle: begin
                if (start) begin
                    op_idx_d = SLOT_A00;
                    state_d  = StLoad;
                end
            end
            StLoad: begin
                // The datapath writes its slot every clock, so these only move on accept.
                if (in_valid) begin
                    sel_in_d    = op_idx_q;
                    input_val_d = in_data;
                    op_idx_d    = op_idx_q + 3'd1;
                    if (op_idx_q == SLOT_B11) begin
                        state_d = StSettle;
                    end
                end
            end
            StSettle: begin
                // Registered strobe: high during the single EXEC cycle.
                execute_d = 1'b1;
                state_d   = StExec;
            end
            StExec: begin
                cnt_d   = CntW'(EXEC_LAT);
                state_d = StWait;
            end
            StWait: begin
                // Leave on the cycle the count would reach zero.
                if (cnt_q <= CntW'(1)) begin
                    res_idx_d = 2'd0;
                    sel_out_d = 2'd0;
                    cnt_d     = CntW'(READ_LAT);
                    state_d   = StRsel;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StRsel: begin
                if (cnt_q <= CntW'(1)) begin
                    out_data_d  = mm_result;
                    out_valid_d = 1'b1;
                    state_d     = StOut;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StOut: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (res_idx_q == LastRes) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        res_idx_d = res_idx_q + 2'd1;
                        sel_out_d = res_idx_q + 2'd1;
                        cnt_d     = CntW'(READ_LAT);
                        state_d   = StRsel;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            op_idx_q     <= 3'd0;
            res_idx_q    <= 2'd0;
            cnt_q        <= '0;
            out_data     <= '0;
            out_valid    <= 1'b0;
            done         <= 1'b0;
            mm_sel_in    <= 3'd0;
            mm_input_val <= '0;
            mm_execute   <= 1'b0;
            mm_sel_out   <= 2'd0;
        end else begin
            state_q      <= state_d;
            op_idx_q     <= op_idx_d;
            res_idx_q    <= res_idx_d;
            cnt_q        <= cnt_d;
            out_data     <= out_data_d;
            out_valid    <= out_valid_d;
            done         <= done_d;
            mm_sel_in    <= sel_in_d;
            mm_input_val <= input_val_d;
            mm_execute   <= execute_d;
            mm_sel_out   <= sel_out_d;
        end
    end

endmodule
